lc3b_address_adder: RTL and testbench
=====================================

// Module: lc3b_address_adder
// PURPOSE
//  - LC-3b datapath address adder: OUT = ADDR1MUX + (ADDR2MUX << LSHFT), all 16-bit.
//  - ADDR1 picks the base (PC or base register SR1).
//  - ADDR2 picks a sign-extended IR offset field (or zero); LSHFT optionally doubles it for word addressing.
//  - Feeds the PC mux (branch/JSR targets) and the MAR (LDB/LDW/STB/STW/LEA) in the LC3 datapath.
// PARAMETERS (selector encodings, hierarchically readable as constants)
//  ADDR1_PC           2'd0  ADDR1 operand = PC
//  ADDR1_BASER        2'd1  ADDR1 operand = SR1 (base register)
//  ADDR2_ZERO         3'd0  ADDR2 operand = 16'h0000
//  ADDR2_OFFSET6      3'd1  ADDR2 operand = SEXT(IR[5:0])
//  ADDR2_PCOFFSET9    3'd2  ADDR2 operand = SEXT(IR[8:0])
//  ADDR2_PCOFFSET11   3'd3  ADDR2 operand = SEXT(IR[10:0])
// PORTS
//  clk        input   1   system clock; no state is clocked, port kept for datapath uniformity
//  reset      input   1   asynchronous, active-high reset; no state to clear, OUT unaffected
//  ADDR1_SEL  input   2   base select (ADDR1_* encodings)
//  ADDR2_SEL  input   3   offset select (ADDR2_* encodings)
//  LSHFT      input   1   1 = shift selected offset left by 1 before adding
//  IR         input  16   instruction register; supplies the offset fields
//  PC         input  16   program counter
//  SR1        input  16   base register value from the register file
//  OUT        output 16   computed address
// BEHAVIOUR
//  - One clock domain: clk. Reset is asynchronous and active-high.
//  - Purely combinational: OUT follows input changes in the same delta, with zero cycles of latency.
//  - clk and reset do not affect OUT; reset asserted mid-operation has no effect.
//  - a1 = (ADDR1_SEL==ADDR1_PC) ? PC : (ADDR1_SEL==ADDR1_BASER) ? SR1 : 16'h0000.
//    Codes 2 and 3 give zero.
//  - a2 (16-bit, sign-extended from the field MSB):
//    - ZERO -> 0.
//    - OFFSET6 -> {{10{IR[5]}},IR[5:0]}.
//    - PCOFFSET9 -> {{7{IR[8]}},IR[8:0]}.
//    - PCOFFSET11 -> {{5{IR[10]}},IR[10:0]}.
//    - Codes 4..7 -> 0.
//  - s = LSHFT ? {a2[14:0],1'b0} : a2. The shift is applied after sign extension, for any ADDR2 selection.
//  - OUT = (a1 + s) mod 2^16. Two's-complement wrap-around, no carry or overflow output.
//  - IR bits outside the selected field are ignored.
//  - X/Z on an unused operand does not propagate to OUT:
//    - PC is don't-care when BASER is selected.
//    - SR1 is don't-care when PC is selected.
//    - IR is don't-care when ZERO is selected.
// TESTING
//  - PC=5, ADDR1_PC, ADDR2_ZERO, LSHFT=0 -> OUT=16'h0005, valid at time 0 with no clock edge.
//  - PC=5, IR=16'h1111, OFFSET6 -> 16'h0016. IR=16'hFFFF, OFFSET6 -> 16'h0004 (sign extension).
//  - PC=5, IR=16'h1011, PCOFFSET9 -> 16'h0016. PC=256, IR=-255 (16'hFF01), PCOFFSET9 -> 16'h0001.
//  - PC=5, IR=16'h1111, PCOFFSET11 -> 16'h0116. PC=200, IR=-100, PCOFFSET11 -> 16'd100.
//  - SR1=16'h0040, ADDR1_BASER, PCOFFSET11, LSHFT=1:
//    - IR=16'h0010 -> 16'h0060.
//    - IR=16'hFFFF -> 16'h003E.
//  - Wrap and reset: PC=16'hFFFF, IR=16'h0001, OFFSET6 -> 16'h0000.
//    Toggle reset and clk while inputs are stable -> OUT unchanged.

Source files
------------

// File: rtl/lc3b_address_adder_if.sv
// Operand and result bundle for the LC-3b address adder.
// master drives the selectors and operands, slave returns the computed address.
interface lc3b_address_adder_if;
  logic [1:0]  ADDR1_SEL;
  logic [2:0]  ADDR2_SEL;
  logic        LSHFT;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [15:0] SR1;
  logic [15:0] OUT;

  modport master (
    output ADDR1_SEL,
    output ADDR2_SEL,
    output LSHFT,
    output IR,
    output PC,
    output SR1,
    input  OUT
  );

  modport slave (
    input  ADDR1_SEL,
    input  ADDR2_SEL,
    input  LSHFT,
    input  IR,
    input  PC,
    input  SR1,
    output OUT
  );
endinterface

// File: rtl/lc3b_address_adder.sv
// LC-3b address adder: OUT = base + (sign-extended IR offset, optionally doubled).
// Purely combinational; clk and reset exist only for datapath port uniformity.
module lc3b_address_adder (
    input  logic                 clk,
    input  logic                 reset,
    lc3b_address_adder_if.slave  bus
);
    localparam logic [1:0] ADDR1_PC         = 2'd0;
    localparam logic [1:0] ADDR1_BASER      = 2'd1;
    localparam logic [2:0] ADDR2_ZERO       = 3'd0;
    localparam logic [2:0] ADDR2_OFFSET6    = 3'd1;
    localparam logic [2:0] ADDR2_PCOFFSET9  = 3'd2;
    localparam logic [2:0] ADDR2_PCOFFSET11 = 3'd3;

    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] s;

    // Only the selected operand is read, so X on an unselected one stays out of OUT.
    always_comb begin
        a1 = '0;
        case (bus.ADDR1_SEL)
            ADDR1_PC:    a1 = bus.PC;
            ADDR1_BASER: a1 = bus.SR1;
            default:     a1 = '0;
        endcase
    end

    always_comb begin
        a2 = '0;
        case (bus.ADDR2_SEL)
            ADDR2_ZERO:       a2 = '0;
            ADDR2_OFFSET6:    a2 = {{10{bus.IR[5]}}, bus.IR[5:0]};
            ADDR2_PCOFFSET9:  a2 = {{7{bus.IR[8]}},  bus.IR[8:0]};
            ADDR2_PCOFFSET11: a2 = {{5{bus.IR[10]}}, bus.IR[10:0]};
            default:          a2 = '0;
        endcase
    end

    always_comb begin
        s = bus.LSHFT ? {a2[14:0], 1'b0} : a2;
    end

    assign bus.OUT = a1 + s;

    // clk, reset and the opcode bits of IR are intentionally not part of the result.
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, bus.IR[15:11]};
endmodule

// File: tb/tb_lc3b_address_adder.sv
// Self-checking bench for lc3b_address_adder: directed table, X isolation,
// clock/reset insensitivity, and random stimulus against an arithmetic model.
module tb_lc3b_address_adder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lc3b_address_adder_if bus_if ();

  lc3b_address_adder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  a1s;
    logic [2:0]  a2s;
    logic        lshft;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] sr1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: OUT=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a1s, input logic [2:0] a2s, input logic lshft,
                       input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] sr1);
    bus_if.ADDR1_SEL = a1s;
    bus_if.ADDR2_SEL = a2s;
    bus_if.LSHFT     = lshft;
    bus_if.IR        = ir;
    bus_if.PC        = pc;
    bus_if.SR1       = sr1;
  endtask

  // Reference: integer arithmetic on the signed offset value, truncated to 16 bits.
  function automatic logic [15:0] model(input logic [1:0] a1s, input logic [2:0] a2s,
                                        input logic lshft, input logic [15:0] ir,
                                        input logic [15:0] pc, input logic [15:0] sr1);
    int base;
    int off;
    int width;
    base = (a1s == 2'd0) ? int'(pc) : (a1s == 2'd1) ? int'(sr1) : 0;
    case (a2s)
      3'd1:    width = 6;
      3'd2:    width = 9;
      3'd3:    width = 11;
      default: width = 0;
    endcase
    if (width == 0) off = 0;
    else begin
      off = int'(ir) % (1 << width);
      if (off >= (1 << (width - 1))) off = off - (1 << width);
    end
    if (lshft) off = off * 2;
    return 16'(base + off);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;

    // Output must be valid at time 0 without any clock edge.
    drive(2'd0, 3'd0, 1'b0, 16'h0000, 16'd5, 16'h0000);
    #1;
    check("time0_pc_zero", bus_if.OUT, 16'h0005);

    vecs.push_back('{"off6_pos",       2'd0, 3'd1, 1'b0, 16'h1111, 16'd5,   16'h0000, 16'h0016});
    vecs.push_back('{"off6_neg",       2'd0, 3'd1, 1'b0, 16'hFFFF, 16'd5,   16'h0000, 16'h0004});
    vecs.push_back('{"off9_pos",       2'd0, 3'd2, 1'b0, 16'h1011, 16'd5,   16'h0000, 16'h0016});
    vecs.push_back('{"off9_neg",       2'd0, 3'd2, 1'b0, 16'hFF01, 16'd256, 16'h0000, 16'h0001});
    vecs.push_back('{"off11_pos",      2'd0, 3'd3, 1'b0, 16'h1111, 16'd5,   16'h0000, 16'h0116});
    vecs.push_back('{"off11_neg",      2'd0, 3'd3, 1'b0, 16'hFF9C, 16'd200, 16'h0000, 16'd100});
    vecs.push_back('{"baser_shl_pos",  2'd1, 3'd3, 1'b1, 16'h0010, 16'h1234, 16'h0040, 16'h0060});
    vecs.push_back('{"baser_shl_neg",  2'd1, 3'd3, 1'b1, 16'hFFFF, 16'h1234, 16'h0040, 16'h003E});
    vecs.push_back('{"wrap",           2'd0, 3'd1, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000});
    vecs.push_back('{"a1_code2_zero",  2'd2, 3'd1, 1'b0, 16'h0003, 16'h1000, 16'h2000, 16'h0003});
    vecs.push_back('{"a1_code3_zero",  2'd3, 3'd0, 1'b0, 16'hFFFF, 16'h1000, 16'h2000, 16'h0000});
    vecs.push_back('{"a2_code4_zero",  2'd0, 3'd4, 1'b1, 16'hFFFF, 16'h0100, 16'h0000, 16'h0100});
    vecs.push_back('{"a2_code7_zero",  2'd1, 3'd7, 1'b0, 16'h07FF, 16'h0100, 16'h0300, 16'h0300});
    vecs.push_back('{"off6_shl_max",   2'd0, 3'd1, 1'b1, 16'hFFDF, 16'h0000, 16'h0000, 16'h003E});
    vecs.push_back('{"off9_ignore_hi", 2'd1, 3'd2, 1'b0, 16'hFE00, 16'h0000, 16'h0010, 16'h0010});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a1s, vecs[i].a2s, vecs[i].lshft, vecs[i].ir, vecs[i].pc, vecs[i].sr1);
      #1;
      check(vecs[i].name, bus_if.OUT, vecs[i].exp);
    end

    // Unselected operands carrying X must not reach OUT.
    @(negedge clk);
    drive(2'd1, 3'd1, 1'b0, 16'h0002, 16'hxxxx, 16'h0100);
    #1;
    check("x_on_pc", bus_if.OUT, 16'h0102);
    drive(2'd0, 3'd3, 1'b0, 16'h0005, 16'h0200, 16'hxxxx);
    #1;
    check("x_on_sr1", bus_if.OUT, 16'h0205);
    drive(2'd0, 3'd0, 1'b1, 16'hxxxx, 16'h0300, 16'h0000);
    #1;
    check("x_on_ir", bus_if.OUT, 16'h0300);

    // Reset and clock activity with stable inputs must leave OUT alone.
    @(negedge clk);
    drive(2'd0, 3'd1, 1'b0, 16'h0001, 16'hFFFF, 16'h0000);
    #1;
    check("hold_before_reset", bus_if.OUT, 16'h0000);
    reset = 1'b1;
    #1;
    check("reset_asserted", bus_if.OUT, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_clocked", bus_if.OUT, 16'h0000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_released", bus_if.OUT, 16'h0000);
    reset = 1'b1;
    drive(2'd1, 3'd2, 1'b1, 16'h00FF, 16'h0000, 16'h1000);
    #1;
    check("change_during_reset", bus_if.OUT, 16'h11FE);
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [1:0]  a1s;
      logic [2:0]  a2s;
      logic        lshft;
      logic [15:0] ir, pc, sr1;
      a1s   = 2'($urandom_range(0, 3));
      a2s   = 3'($urandom_range(0, 7));
      lshft = 1'($urandom_range(0, 1));
      ir    = 16'($urandom);
      pc    = 16'($urandom);
      sr1   = 16'($urandom);
      @(negedge clk);
      drive(a1s, a2s, lshft, ir, pc, sr1);
      #1;
      check("random", bus_if.OUT, model(a1s, a2s, lshft, ir, pc, sr1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
